multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the 16-bit Harvard processor, and the initiator side of the ALU interface. It takes the opcode from the instruction register, the ALU `zero` flag and the data-memory ready handshake. From these it sequences fetch, decode, execute, memory and writeback. It drives `alu_control`, the datapath muxes, register-file write and data-memory strobes, and sits between the IR/ALU/regfile datapath and data memory.

## Interface
- `MEM_TIMEOUT`, default 15: maximum MEM-state cycles waiting for `dmem_ready` before faulting (1..255).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  4  instr[15:12] from the instruction register.
- `zero`  in  1  ALU zero flag.
- `dmem_ready`  in  1  data memory completes the current read/write this cycle.
- `ir_write`  out  1  load instruction register from instruction memory.
- `pc_write`  out  1  update PC at clock edge.
- `pc_src`  out  2  00 = pc+1, 01 = branch target, 10 = jump target.
- `alu_control`  out  3  001 = add, 010 = sub.
- `alu_src_b`  out  1  0 = register rt, 1 = sign-extended imm.
- `reg_write`  out  1  register-file write enable.
- `mem_to_reg`  out  1  writeback source: 0 = ALU result, 1 = memory data.
- `dmem_read`, `dmem_write`  out  1 each  data-memory strobes.
- `halted`  out  1  FSM in HALT.
- `fault`  out  1  illegal opcode or memory timeout; sticky until reset.

## Operation
- **Opcodes:**
  - 0000 NOP, 0001 ADD, 0010 SUB, 0011 ADDI, 0100 LW, 0101 SW, 0110 BEQ, 0111 J, 1111 HALT.
  - All other opcodes are illegal.
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **Outputs are Moore-decoded** from state plus a latched opcode register. Defaults are all 0 and `alu_control`=001.
- **IDLE:** entered by reset; all defaults; goes to FETCH next cycle.
- **FETCH:** `ir_write`=1; goes to DECODE.
- **DECODE:** latches `opcode` into the internal op register.
  - Illegal opcode: go to HALT with `fault`=1.
  - HALT: go to HALT.
  - Otherwise: go to EXEC.
- **EXEC:**
  - ADD/ADDI: `alu_control`=001, `alu_src_b`=ADDI; go to WB.
  - SUB: `alu_control`=010; go to WB.
  - LW/SW: `alu_control`=001, `alu_src_b`=1; go to MEM.
  - BEQ: `alu_control`=010, `pc_write`=1, `pc_src`=`zero` ? 01 : 00; go to FETCH.
  - J: `pc_write`=1, `pc_src`=10; go to FETCH.
  - NOP: `pc_write`=1, `pc_src`=00; go to FETCH.
- **MEM:**
  - Holds `alu_control`=001 and `alu_src_b`=1, so the address is stable.
  - Asserts `dmem_read` (LW) or `dmem_write` (SW) continuously until `dmem_ready`.
  - On `dmem_ready`, LW goes to WB.
  - On `dmem_ready`, SW asserts `pc_write`=1 with `pc_src`=00 in that same cycle, then goes to FETCH.
  - Wait counter counts MEM cycles without ready. If `dmem_ready` is still low after `MEM_TIMEOUT` cycles, go to HALT with `fault`=1. The counter clears on MEM entry.
- **WB:**
  - `alu_control` and `alu_src_b` are held at their EXEC values.
  - `reg_write`=1, `mem_to_reg`=(op==LW), `pc_write`=1, `pc_src`=00; go to FETCH.
- **HALT:** all strobes 0, `halted`=1, `fault` holds. Only reset exits.

## Timing
- **Reset:** any cycle with `reset`=1 forces state IDLE, wait counter 0, `fault` 0 on the next edge, including mid-MEM.
- **Reset values:** all outputs 0 except `alu_control`=001.
- **Latency, FETCH to next FETCH:**
  - NOP/J/BEQ: 3 cycles.
  - ADD/SUB/ADDI: 4 cycles.
  - SW: 4 + w cycles.
  - LW: 5 + w cycles.
  - w = MEM cycles before `dmem_ready`; w=0 when ready is high in the first MEM cycle.
- **`dmem_ready` sampling:** it is sampled only in MEM and ignored in all other states.
- **Timeout boundary:** ready arriving on the same cycle as the timeout completes normally; ready has priority.
- **BEQ:** `zero` is sampled combinationally during EXEC.
- **Strobe widths:** `pc_write` fires exactly once per instruction and never in HALT; `ir_write` fires exactly once per instruction.

## Structure
- **Shared package `cpu_ctrl_pkg`:**
  - Opcode constants.
  - `alu_control` encodings (001 add, 010 sub), also imported by the ALU.
  - `pc_src` encodings.
  - State enum.
- **Sub-modules:** none. The FSM, op register and wait counter are a single module.

## Test plan
- **Reset then NOP:** `reset` high 2 cycles, `opcode`=0000 → outputs at reset values, then `ir_write` at cycle 2 after deassert; `pc_write`/`pc_src`=00 in EXEC; back to FETCH after 3 cycles.
- **ADD then ADDI:** → EXEC/WB `alu_control`=001, `alu_src_b`=0 then 1; `reg_write`=1 in WB only; 4 cycles each.
- **BEQ:**
  - With `zero`=1 → `pc_src`=01, `pc_write`=1.
  - With `zero`=0 → `pc_src`=00; `alu_control`=010 in EXEC.
- **LW with `dmem_ready` after 3 MEM cycles:**
  - `dmem_read` high exactly 4 cycles, address controls stable throughout.
  - WB with `mem_to_reg`=1; total 8 cycles.
  - Repeat for SW → `pc_write` on the ready cycle.
- **Timeout:** SW with `dmem_ready` held 0 → HALT after 15 MEM cycles with `fault`=1, `halted`=1. Ready on cycle 15 instead completes normally.
- **Faults and reset recovery:**
  - Illegal opcode 1010 → HALT, `fault`=1.
  - HALT opcode → `halted`=1, `fault`=0.
  - Reset asserted mid-MEM → IDLE with all strobes 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcode, ALU, PC-source and control-state definitions
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_J    = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM driving the ALU, datapath muxes and data memory
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic       halted,
  output logic       fault
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] op;
  logic [7:0] wait_cnt;
  logic       fault_r;
  logic       fault_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op       <= OP_NOP;
      wait_cnt <= '0;
      fault_r  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op <= opcode;
      // Held at zero outside MEM so every MEM visit starts a fresh count.
      if (state != S_MEM) wait_cnt <= '0;
      else if (!dmem_ready) wait_cnt <= wait_cnt + 8'd1;
      if (fault_set) fault_r <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    fault_set   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SEQ;
    alu_control = ALU_ADD;
    alu_src_b   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    halted      = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        ir_write   = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        if (!op_is_legal(opcode)) begin
          state_next = S_HALT;
          fault_set  = 1'b1;
        end else if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_ADD, OP_ADDI: begin
            alu_src_b  = (op == OP_ADDI);
            state_next = S_WB;
          end
          OP_SUB: begin
            alu_control = ALU_SUB;
            state_next  = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b  = 1'b1;
            state_next = S_MEM;
          end
          OP_BEQ: begin
            alu_control = ALU_SUB;
            pc_write    = 1'b1;
            pc_src      = zero ? PC_BRANCH : PC_SEQ;
            state_next  = S_FETCH;
          end
          OP_J: begin
            pc_write   = 1'b1;
            pc_src     = PC_JUMP;
            state_next = S_FETCH;
          end
          default: begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        alu_src_b  = 1'b1;
        dmem_read  = (op == OP_LW);
        dmem_write = (op == OP_SW);
        // Ready wins over timeout when both land in the same cycle.
        if (dmem_ready) begin
          if (op == OP_LW) begin
            state_next = S_WB;
          end else begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_HALT;
          fault_set  = 1'b1;
        end
      end

      S_WB: begin
        alu_control = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
        alu_src_b   = (op == OP_ADDI) || (op == OP_LW);
        reg_write   = 1'b1;
        mem_to_reg  = (op == OP_LW);
        pc_write    = 1'b1;
        state_next  = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_IDLE;
    endcase
  end

  assign fault = fault_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  typedef struct packed {
    logic       ir;
    logic       pw;
    logic [1:0] ps;
    logic [2:0] alu;
    logic       b;
    logic       rw;
    logic       m2r;
    logic       rd;
    logic       wr;
    logic       h;
    logic       f;
  } outv_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       z;
    int         w;
    int         lat;
    int         rw;
    int         ps;
    int         rd;
    int         wr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       ir_write, pc_write, alu_src_b, reg_write, mem_to_reg;
  logic       dmem_read, dmem_write, halted, fault;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  outv_t      act;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_control(alu_control),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign act = {ir_write, pc_write, pc_src, alu_control, alu_src_b, reg_write,
                mem_to_reg, dmem_read, dmem_write, halted, fault};

  function automatic outv_t dflt();
    outv_t e;
    e = '0;
    e.alu = 3'b001;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic check_v(input string name, input outv_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (ir pw ps alu b rw m2r rd wr h f)", name, act, e);
    end
  endtask

  task automatic check_i(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic z, input logic rdy, input outv_t e,
                     input string name);
    @(negedge clk);
    opcode = op;
    zero = z;
    dmem_ready = rdy;
    #1;
    check_v(name, e);
  endtask

  // Leaves the bench at a point where the next cycle is FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    zero = rb();
    dmem_ready = rb();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_v("reset_state", dflt());
    reset = 1'b0;
  endtask

  task automatic halt_cycles(input logic f);
    outv_t e;
    for (int i = 0; i < 3; i++) begin
      e = dflt();
      e.h = 1'b1;
      e.f = f;
      cyc(4'($urandom), rb(), rb(), e, "ref_halt");
    end
  endtask

  // Instruction-level reference: expands one instruction into its expected cycle trace.
  task automatic run_ref(input logic [3:0] op, input int w, input logic zx, output bit stopped);
    outv_t e;
    bit    legal;
    int    n;
    bit    rdy;
    legal = (op <= 4'd7) || (op == 4'hF);
    stopped = 1'b0;
    e = dflt();
    e.ir = 1'b1;
    cyc(op, rb(), rb(), e, "ref_fetch");
    cyc(op, rb(), rb(), dflt(), "ref_decode");
    if (!legal || op == 4'hF) begin
      halt_cycles(!legal);
      stopped = 1'b1;
      return;
    end
    e = dflt();
    case (op)
      4'd0: e.pw = 1'b1;
      4'd2: e.alu = 3'b010;
      4'd3, 4'd4, 4'd5: e.b = 1'b1;
      4'd6: begin e.alu = 3'b010; e.pw = 1'b1; e.ps = zx ? 2'b01 : 2'b00; end
      4'd7: begin e.pw = 1'b1; e.ps = 2'b10; end
      default: ;
    endcase
    cyc(4'($urandom), (op == 4'd6) ? zx : rb(), rb(), e, "ref_exec");
    if (op == 4'd0 || op == 4'd6 || op == 4'd7) return;
    if (op == 4'd4 || op == 4'd5) begin
      n = (w >= TMO) ? TMO : w + 1;
      for (int i = 0; i < n; i++) begin
        rdy = (w < TMO) && (i == w);
        e = dflt();
        e.b = 1'b1;
        e.rd = (op == 4'd4);
        e.wr = (op == 4'd5);
        e.pw = rdy && (op == 4'd5);
        cyc(4'($urandom), rb(), rdy, e, "ref_mem");
      end
      if (w >= TMO) begin
        halt_cycles(1'b1);
        stopped = 1'b1;
        return;
      end
      if (op == 4'd5) return;
    end
    e = dflt();
    e.alu = (op == 4'd2) ? 3'b010 : 3'b001;
    e.b = (op == 4'd3) || (op == 4'd4);
    e.rw = 1'b1;
    e.m2r = (op == 4'd4);
    e.pw = 1'b1;
    cyc(4'($urandom), rb(), rb(), e, "ref_wb");
  endtask

  // Measures one instruction from FETCH to the next FETCH, answering dmem strobes after w waits.
  task automatic run_vec(input vec_t v);
    int lat, rw, pw, rd, wr, memc, bad, ps;
    lat = -1; rw = 0; pw = 0; rd = 0; wr = 0; memc = 0; bad = 0; ps = -1;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      opcode = v.op;
      zero = v.z;
      dmem_ready = (dmem_read || dmem_write) && (memc == v.w);
      #1;
      if (k > 0 && ir_write) begin
        lat = k;
        break;
      end
      if (k == 0 && !ir_write) bad++;
      if (reg_write) rw++;
      if (pc_write) begin pw++; ps = int'(pc_src); end
      if (dmem_read || dmem_write) begin
        memc++;
        if (alu_control != 3'b001 || !alu_src_b) bad++;
      end
      if (dmem_read) rd++;
      if (dmem_write) wr++;
    end
    check_i({v.name, "_latency"}, lat, v.lat);
    check_i({v.name, "_pc_write_count"}, pw, 1);
    check_i({v.name, "_pc_src"}, ps, v.ps);
    check_i({v.name, "_reg_write_count"}, rw, v.rw);
    check_i({v.name, "_dmem_read_count"}, rd, v.rd);
    check_i({v.name, "_dmem_write_count"}, wr, v.wr);
    check_i({v.name, "_addr_stable"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[11];
    bit    stopped;
    outv_t e;
    logic [3:0] rop;
    int    rw_;

    tbl[0]  = '{"nop",     4'h0, 1'b0, 0,  3,  0, 0, 0,  0};
    tbl[1]  = '{"add",     4'h1, 1'b1, 0,  4,  1, 0, 0,  0};
    tbl[2]  = '{"addi",    4'h3, 1'b0, 0,  4,  1, 0, 0,  0};
    tbl[3]  = '{"sub",     4'h2, 1'b0, 0,  4,  1, 0, 0,  0};
    tbl[4]  = '{"beq_z1",  4'h6, 1'b1, 0,  3,  0, 1, 0,  0};
    tbl[5]  = '{"beq_z0",  4'h6, 1'b0, 0,  3,  0, 0, 0,  0};
    tbl[6]  = '{"jump",    4'h7, 1'b1, 0,  3,  0, 2, 0,  0};
    tbl[7]  = '{"lw_w3",   4'h4, 1'b0, 3,  8,  1, 0, 4,  0};
    tbl[8]  = '{"sw_w3",   4'h5, 1'b0, 3,  7,  0, 0, 0,  4};
    tbl[9]  = '{"lw_w0",   4'h4, 1'b1, 0,  5,  1, 0, 1,  0};
    tbl[10] = '{"sw_w14",  4'h5, 1'b0, 14, 18, 0, 0, 0, 15};

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Hand sequences: timeout, ready on the timeout cycle, illegal, halt, reset mid-MEM.
    do_reset();
    run_ref(4'h5, TMO - 1, 1'b0, stopped);
    check_i("sw_ready_on_last_cycle_completes", int'(stopped), 0);
    run_ref(4'h4, TMO - 1, 1'b0, stopped);
    run_ref(4'h5, TMO, 1'b0, stopped);
    check_i("sw_timeout_halts", int'(stopped), 1);
    do_reset();
    run_ref(4'hA, 0, 1'b0, stopped);
    do_reset();
    run_ref(4'hF, 0, 1'b0, stopped);
    do_reset();
    e = dflt(); e.ir = 1'b1;
    cyc(4'h4, 1'b0, 1'b0, e, "midmem_fetch");
    cyc(4'h4, 1'b0, 1'b1, dflt(), "midmem_decode");
    e = dflt(); e.b = 1'b1;
    cyc(4'h0, 1'b0, 1'b1, e, "midmem_exec");
    e.rd = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'h0, 1'b0, 1'b0, e, "midmem_wait");
    do_reset();
    run_ref(4'h0, 0, 1'b0, stopped);

    // Randomized instruction stream against the reference expansion.
    for (int i = 0; i < 150; i++) begin
      rw_ = $urandom_range(99);
      if (rw_ < 88) rop = 4'($urandom_range(7));
      else if (rw_ < 94) rop = 4'hF;
      else rop = 4'($urandom_range(14, 8));
      run_ref(rop, ($urandom_range(9) == 0) ? TMO : $urandom_range(TMO - 1), rb(), stopped);
      if (stopped) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
